// File: rtl/des_pkg.sv
// Shared DES permutation constants and the run-time mode encoding.
// Table entries are 0-based source indices: out[k] = in[TABLE[k]].
package des_pkg;

  localparam int DES_BLK_W = 64;

  typedef enum logic [1:0] {
    IP      = 2'b00,
    FP      = 2'b01,
    SWAP_FP = 2'b10,
    BYPASS  = 2'b11
  } des_perm_mode_t;

  localparam logic [5:0] FP_TABLE [64] = '{
    6'd39, 6'd7, 6'd47, 6'd15, 6'd55, 6'd23, 6'd63, 6'd31,
    6'd38, 6'd6, 6'd46, 6'd14, 6'd54, 6'd22, 6'd62, 6'd30,
    6'd37, 6'd5, 6'd45, 6'd13, 6'd53, 6'd21, 6'd61, 6'd29,
    6'd36, 6'd4, 6'd44, 6'd12, 6'd52, 6'd20, 6'd60, 6'd28,
    6'd35, 6'd3, 6'd43, 6'd11, 6'd51, 6'd19, 6'd59, 6'd27,
    6'd34, 6'd2, 6'd42, 6'd10, 6'd50, 6'd18, 6'd58, 6'd26,
    6'd33, 6'd1, 6'd41, 6'd9,  6'd49, 6'd17, 6'd57, 6'd25,
    6'd32, 6'd0, 6'd40, 6'd8,  6'd48, 6'd16, 6'd56, 6'd24
  };

  localparam logic [5:0] IP_TABLE [64] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
    6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
    6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,
    6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,  6'd0,
    6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
    6'd60, 6'd52, 6'd44, 6'd36, 6'd28, 6'd20, 6'd12, 6'd4,
    6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6
  };

endpackage

// File: rtl/des_perm_lane.sv
// Combinational 64-bit DES bit permutation for one lane, selected by mode.
module des_perm_lane
  import des_pkg::*;
(
  input  logic [63:0]    blk_i,
  input  des_perm_mode_t mode_i,
  output logic [63:0]    blk_o
);

  logic [63:0] swap_s;
  logic [63:0] ip_s;
  logic [63:0] fp_s;
  logic [63:0] fps_s;

  assign swap_s = {blk_i[31:0], blk_i[63:32]};

  // Pure wiring through the constant tables.
  always_comb begin
    ip_s  = '0;
    fp_s  = '0;
    fps_s = '0;
    for (int k = 0; k < 64; k++) begin
      ip_s[k]  = blk_i[IP_TABLE[k]];
      fp_s[k]  = blk_i[FP_TABLE[k]];
      fps_s[k] = swap_s[FP_TABLE[k]];
    end
  end

  // Mode select.
  always_comb begin
    blk_o = blk_i;
    case (mode_i)
      IP:      blk_o = ip_s;
      FP:      blk_o = fp_s;
      SWAP_FP: blk_o = fps_s;
      BYPASS:  blk_o = blk_i;
      default: blk_o = blk_i;
    endcase
  end

endmodule

// File: rtl/des_perm_pipe.sv
// Handshaked multi-lane DES permutation pipeline: stage 1 permutes, later
// stages only delay. Ready ripples combinationally back from OutReady.
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int CNT_W  = 3
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [1:0]                 InMode,
  input  logic [DES_BLK_W*LANES-1:0] DataIn,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [DES_BLK_W*LANES-1:0] DataOut,
  output logic [1:0]                 OutMode,
  output logic [CNT_W-1:0]           InFlight,
  input  logic                       Flush
);

  localparam int DW = DES_BLK_W * LANES;

  des_perm_mode_t    in_mode_s;
  logic [DW-1:0]     perm_s;
  logic [STAGES-1:0] load_s;
  logic              acc_s;
  logic              emit_s;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [DW-1:0]     data_q [STAGES];
  logic [DW-1:0]     data_d [STAGES];
  des_perm_mode_t    mode_q [STAGES];
  des_perm_mode_t    mode_d [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign in_mode_s = des_perm_mode_t'(InMode);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    des_perm_lane u_lane (
      .blk_i  (DataIn[DES_BLK_W*l +: DES_BLK_W]),
      .mode_i (in_mode_s),
      .blk_o  (perm_s[DES_BLK_W*l +: DES_BLK_W])
    );
  end

  // A stage can load unless it and every stage after it are full and stalled.
  always_comb begin : load_calc
    logic tail_full;
    tail_full = 1'b1;
    load_s    = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      tail_full = tail_full & vld_q[s];
      load_s[s] = OutReady | ~tail_full;
    end
  end

  assign InReady = load_s[0];
  assign acc_s   = InValid & load_s[0];
  assign emit_s  = vld_q[STAGES-1] & OutReady;

  // Next state for the stage registers and occupancy count.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    if (load_s[0]) begin
      vld_d[0] = InValid;
    end else begin
      vld_d[0] = vld_q[0];
    end
    if (acc_s) begin
      data_d[0] = perm_s;
      mode_d[0] = in_mode_s;
    end else begin
      data_d[0] = data_q[0];
    end
    for (int s = 1; s < STAGES; s++) begin
      if (load_s[s]) begin
        vld_d[s] = vld_q[s-1];
        if (vld_q[s-1]) begin
          data_d[s] = data_q[s-1];
          mode_d[s] = mode_q[s-1];
        end else begin
          data_d[s] = data_q[s];
        end
      end else begin
        vld_d[s] = vld_q[s];
      end
    end
    if (Flush) begin
      vld_d = '0;
      cnt_d = '0;
    end else if (acc_s && !emit_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!acc_s && emit_s) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stage registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        mode_q[s] <= IP;
      end
    end else begin
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      mode_q <= mode_d;
    end
  end

  assign OutValid = vld_q[STAGES-1];
  assign DataOut  = data_q[STAGES-1];
  assign OutMode  = mode_q[STAGES-1];
  assign InFlight = cnt_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe (LANES=1/STAGES=2 and LANES=2/STAGES=4)
// with a scoreboard built from an arithmetic model of the DES tables.
module tb_des_perm_pipe;

  logic         clk, rst_n;
  logic         v0, r0, ov0, or0, fl0;
  logic [1:0]   m0, om0;
  logic [63:0]  d0, do0;
  logic [2:0]   if0;
  logic         v1, r1, ov1, or1, fl1;
  logic [1:0]   m1, om1;
  logic [127:0] d1, do1;
  logic [2:0]   if1;

  int total = 0;
  int bad   = 0;
  int rx0   = 0;
  int rx1   = 0;
  logic [65:0]  q0 [$];
  logic [129:0] q1 [$];

  des_perm_pipe #(.LANES(1), .STAGES(2), .CNT_W(3)) u_dut0 (
    .Clk(clk), .Rst_n(rst_n), .InValid(v0), .InReady(r0), .InMode(m0),
    .DataIn(d0), .OutValid(ov0), .OutReady(or0), .DataOut(do0),
    .OutMode(om0), .InFlight(if0), .Flush(fl0)
  );

  des_perm_pipe #(.LANES(2), .STAGES(4), .CNT_W(3)) u_dut1 (
    .Clk(clk), .Rst_n(rst_n), .InValid(v1), .InReady(r1), .InMode(m1),
    .DataIn(d1), .OutValid(ov1), .OutReady(or1), .DataOut(do1),
    .OutMode(om1), .InFlight(if1), .Flush(fl1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // FP source index from the table's row/column structure (1-based entry - 1).
  function automatic int fp_src(input int k);
    int r, c;
    r = k / 8;
    c = k % 8;
    return ((c % 2 == 0) ? 40 : 4) + 4 * c - r - 1;
  endfunction

  function automatic logic [63:0] m_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[k] = x[fp_src(k)];
    return y;
  endfunction

  function automatic logic [63:0] m_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[fp_src(k)] = x[k];
    return y;
  endfunction

  function automatic logic [63:0] m_perm(input logic [63:0] x, input logic [1:0] m);
    case (m)
      2'b00:   return m_ip(x);
      2'b01:   return m_fp(x);
      2'b10:   return m_fp({x[31:0], x[63:32]});
      default: return x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [65:0]  e0;
    logic [129:0] e1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (ov0 && or0) begin
        chk("sb0_pending", 132'(q0.size() != 0), 132'(1'b1));
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          chk("sb0_data", 132'({om0, do0}), 132'(e0));
        end
        rx0++;
      end
      if (v0 && r0 && !fl0) q0.push_back({m0, m_perm(d0, m0)});
      if (fl0) q0.delete();
      if (ov1 && or1) begin
        chk("sb1_pending", 132'(q1.size() != 0), 132'(1'b1));
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          chk("sb1_data", 132'({om1, do1}), 132'(e1));
        end
        rx1++;
      end
      if (v1 && r1 && !fl1) q1.push_back({m1, m_perm(d1[127:64], m1), m_perm(d1[63:0], m1)});
      if (fl1) q1.delete();
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  // One beat through dut0 with no back-pressure; checks latency and mode.
  task automatic run0(input logic [63:0] d, input logic [1:0] m, output logic [63:0] res);
    v0 = 1'b1; d0 = d; m0 = m;
    tick();
    v0 = 1'b0;
    chk("lat0_early", 132'(ov0), 132'(1'b0));
    tick();
    chk("lat0", 132'(ov0), 132'(1'b1));
    chk("mode0", 132'(om0), 132'(m));
    res = do0;
    tick();
  endtask

  initial begin
    logic [63:0] res, rt, hold;
    logic [63:0] bp_data [8];
    logic [1:0]  bp_mode [8];
    int sent, rx_start, lat;
    logic acc, seen;
    const logic [63:0] c = 64'h0123_4567_89AB_CDEF;

    rst_n = 1'b0;
    v0 = 1'b0; m0 = 2'b00; d0 = '0; or0 = 1'b1; fl0 = 1'b0;
    v1 = 1'b0; m1 = 2'b00; d1 = '0; or1 = 1'b1; fl1 = 1'b0;
    #12;
    chk("rst_ov0", 132'(ov0), 132'(1'b0));
    chk("rst_do0", 132'(do0), 132'(64'h0));
    chk("rst_om0", 132'(om0), 132'(2'b00));
    chk("rst_if0", 132'(if0), 132'(3'd0));
    chk("rst_ov1", 132'(ov1), 132'(1'b0));
    chk("rst_do1", 132'(do1), 132'(128'h0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rdy0_after_rst", 132'(r0), 132'(1'b1));
    chk("rdy1_after_rst", 132'(r1), 132'(1'b1));

    run0(64'h1, 2'b00, res);
    chk("ip_bit0", 132'(res), 132'(64'h0000_0080_0000_0000));
    run0(64'h0000_0080_0000_0000, 2'b01, res);
    chk("fp_bit39", 132'(res), 132'(64'h1));

    run0(c, 2'b00, rt);
    run0(rt, 2'b01, res);
    chk("round_trip", 132'(res), 132'(c));
    run0(c, 2'b10, res);
    chk("swap_fp", 132'(res), 132'(m_fp(64'h89AB_CDEF_0123_4567)));
    run0(c, 2'b11, res);
    chk("bypass", 132'(res), 132'(c));

    // Back-pressure: 8 streamed beats, OutReady low in cycles 3..6.
    for (int j = 0; j < 8; j++) begin
      bp_data[j] = {$urandom, $urandom};
      bp_mode[j] = 2'($urandom_range(0, 3));
    end
    sent = 0;
    rx_start = rx0;
    hold = '0;
    for (int i = 0; i < 16; i++) begin
      v0  = (sent < 8);
      d0  = bp_data[sent % 8];
      m0  = bp_mode[sent % 8];
      or0 = !(i >= 3 && i <= 6);
      #1;
      if (i == 3) hold = do0;
      if (i == 6) begin
        chk("bp_inflight_sat", 132'(if0), 132'(3'd2));
        chk("bp_ready_low", 132'(r0), 132'(1'b0));
        chk("bp_data_hold", 132'(do0), 132'(hold));
      end
      if (i >= 7 && i <= 13) chk("bp_tput", 132'(ov0), 132'(1'b1));
      acc = v0 && r0;
      tick();
      if (acc) sent++;
    end
    v0 = 1'b0;
    or0 = 1'b1;
    chk("bp_count", 132'(rx0 - rx_start), 132'(8));
    chk("bp_sb_empty", 132'(q0.size()), 132'(0));

    // Two lanes, four stages.
    v1 = 1'b1; m1 = 2'b01;
    d1 = {64'h0000_0080_0000_0000, 64'h1};
    tick();
    v1 = 1'b0;
    lat = 1;
    while (!ov1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("lat1", 132'(lat), 132'(4));
    chk("lane0_fp", 132'(do1[63:0]), 132'(m_fp(64'h1)));
    chk("lane1_fp", 132'(do1[127:64]), 132'(64'h1));
    tick();

    // Async reset with three beats in flight.
    for (int j = 0; j < 3; j++) begin
      v1 = 1'b1; m1 = 2'(j); d1 = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    v1 = 1'b0;
    chk("rst_mid_inflight", 132'(if1), 132'(3'd3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ov1", 132'(ov1), 132'(1'b0));
    chk("rst_mid_if1", 132'(if1), 132'(3'd0));
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 6; j++) begin
      seen |= ov1;
      tick();
    end
    chk("rst_no_output", 132'(seen), 132'(1'b0));

    // Flush with a simultaneous accept and emit.
    v0 = 1'b1; m0 = 2'b01; d0 = 64'h1111_2222_3333_4444;
    tick();
    d0 = 64'h5555_6666_7777_8888;
    tick();
    d0 = 64'h9999_AAAA_BBBB_CCCC; m0 = 2'b11; fl0 = 1'b1;
    #1;
    chk("flush_ready", 132'(r0), 132'(1'b1));
    chk("flush_emit_valid", 132'(ov0), 132'(1'b1));
    rx_start = rx0;
    tick();
    v0 = 1'b0; fl0 = 1'b0;
    chk("flush_delivered", 132'(rx0 - rx_start), 132'(1));
    chk("flush_inflight", 132'(if0), 132'(3'd0));
    seen = 1'b0;
    for (int j = 0; j < 4; j++) begin
      seen |= ov0;
      tick();
    end
    chk("flush_no_output", 132'(seen), 132'(1'b0));
    chk("end_sb0_empty", 132'(q0.size()), 132'(0));
    chk("end_sb1_empty", 132'(q1.size()), 132'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
